mvau_weight_stream_sequencer: RTL and testbench

- Sequences weight-memory reads for the MVAU streaming datapath and presents weight tiles as a valid/ready stream to the stream unit's weight input.
- Tile order is nf-major, sf-minor (addr = nf*SF + sf), which matches the stream unit's sf/nf counters.
- The full SF*NF sequence is replayed once per input vector, NUM_REPS times per start.
- A 2-entry output FIFO absorbs the memory's 1-cycle read latency, giving 1 tile/cycle sustained with no bubbles under backpressure.

---
 rtl/mvau_weight_stream_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_mvau_weight_stream_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvau_weight_stream_sequencer.sv
// Weight-tile sequencer for the MVAU streaming datapath.
// Walks the weight memory nf-major / sf-minor, replays the full tile set once
// per input vector, and hands tiles downstream through a 2-deep
// first-word-fall-through buffer that hides the memory's 1-cycle read latency.
module mvau_weight_stream_sequencer #(
  parameter int unsigned SIMD     = 2,
  parameter int unsigned PE       = 2,
  parameter int unsigned TW       = 1,
  parameter int unsigned SF       = 8,
  parameter int unsigned NF       = 2,
  parameter int unsigned NUM_REPS = 4,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned REP_T    = 2
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   wmem_en,
  output logic [ADDR_W-1:0]      wmem_addr,
  input  logic [SIMD*PE*TW-1:0]  wmem_rdata,
  output logic [SIMD*PE*TW-1:0]  wgt_out,
  output logic                   wgt_out_v,
  input  logic                   wgt_out_rdy,
  output logic                   wgt_out_last
);

  localparam int unsigned         DW        = SIMD * PE * TW;
  localparam logic [ADDR_W-1:0]   ADDR_LAST = ADDR_W'(SF * NF - 1);
  localparam logic [REP_T-1:0]    REP_LAST  = REP_T'(NUM_REPS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [REP_T-1:0]  r_rep;
  logic              r_busy;
  logic              r_done;
  logic              r_inflight;
  logic              r_infl_last;
  logic [DW-1:0]     r_d0;
  logic [DW-1:0]     r_d1;
  logic              r_l0;
  logic              r_l1;
  logic [1:0]        r_cnt;

  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  logic [2:0]        w_occ;

  // Issue a read only if, after this cycle's pop, buffer plus in-flight read still leaves a slot.
  always_comb begin
    w_pop   = (r_cnt != 2'd0) && wgt_out_rdy;
    w_push  = r_inflight;
    w_occ   = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    w_issue = (r_state == S_RUN) && (w_occ < 3'd2);
  end

  assign wmem_en      = w_issue;
  assign wmem_addr    = r_addr;
  assign wgt_out      = r_d0;
  assign wgt_out_last = r_l0;
  assign wgt_out_v    = (r_cnt != 2'd0);
  assign busy         = r_busy;
  assign done         = r_done;

  // Sequencing FSM: address/replay counters plus registered busy/done.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_rep   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_addr  <= '0;
            r_rep   <= '0;
          end
        end
        S_RUN: begin
          if (w_issue) begin
            if (r_addr == ADDR_LAST) begin
              r_addr <= '0;
              if (r_rep == REP_LAST) begin
                r_rep   <= '0;
                r_state <= S_DRAIN;
              end else begin
                r_rep <= r_rep + REP_T'(1);
              end
            end else begin
              r_addr <= r_addr + ADDR_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if ((r_cnt == 2'd0) && !r_inflight) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read pipeline: mark the cycle the read data returns and carry its end-of-replay flag.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_inflight  <= 1'b0;
      r_infl_last <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_infl_last <= (r_addr == ADDR_LAST);
      end
    end
  end

  // Two-entry shift buffer; slot 0 is always the head presented downstream.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_d0  <= '0;
      r_d1  <= '0;
      r_l0  <= 1'b0;
      r_l1  <= 1'b0;
      r_cnt <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) begin
            r_d0 <= wmem_rdata;
            r_l0 <= r_infl_last;
          end else begin
            r_d1 <= wmem_rdata;
            r_l1 <= r_infl_last;
          end
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_d0  <= r_d1;
          r_l0  <= r_l1;
          r_cnt <= r_cnt - 2'd1;
        end
        2'b11: begin
          // Count unchanged: the incoming word lands behind whatever stays buffered.
          if (r_cnt == 2'd1) begin
            r_d0 <= wmem_rdata;
            r_l0 <= r_infl_last;
          end else begin
            r_d0 <= r_d1;
            r_l0 <= r_l1;
            r_d1 <= wmem_rdata;
            r_l1 <= r_infl_last;
          end
        end
        default: begin
        end
      endcase
    end
  end

  ap_no_overflow: assert property (@(posedge aclk) disable iff (!aresetn)
    !(w_push && (r_cnt == 2'd2)));

endmodule

// File: tb/tb_mvau_weight_stream_sequencer.sv
// Bench for mvau_weight_stream_sequencer: a tile-list reference model checked
// every cycle, plus a minimal 1x1x1 configuration checked against fixed patterns.
module tb_mvau_weight_stream_sequencer;

  localparam int A_TILES = 8;
  localparam int A_REPS  = 3;
  localparam int A_TOTAL = A_TILES * A_REPS;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       a_start, a_busy, a_done, a_en, a_v, a_rdy, a_last;
  logic [2:0] a_addr;
  logic [7:0] a_rdata, a_wgt;
  logic       b_start, b_busy, b_done, b_en, b_v, b_rdy, b_last;
  logic [0:0] b_addr;
  logic [7:0] b_rdata, b_wgt;

  logic [7:0] mem_a [A_TILES];
  logic [7:0] mem_b;

  always @(posedge clk) if (a_en) a_rdata <= mem_a[a_addr];
  always @(posedge clk) if (b_en) b_rdata <= mem_b;

  mvau_weight_stream_sequencer #(
    .SIMD(2), .PE(2), .TW(2), .SF(4), .NF(2), .NUM_REPS(3), .ADDR_W(3), .REP_T(2)
  ) dut_a (
    .aclk(clk), .aresetn(rst_n), .start(a_start), .busy(a_busy), .done(a_done),
    .wmem_en(a_en), .wmem_addr(a_addr), .wmem_rdata(a_rdata), .wgt_out(a_wgt),
    .wgt_out_v(a_v), .wgt_out_rdy(a_rdy), .wgt_out_last(a_last)
  );

  mvau_weight_stream_sequencer #(
    .SIMD(2), .PE(2), .TW(2), .SF(1), .NF(1), .NUM_REPS(1), .ADDR_W(1), .REP_T(1)
  ) dut_b (
    .aclk(clk), .aresetn(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
    .wmem_en(b_en), .wmem_addr(b_addr), .wmem_rdata(b_rdata), .wgt_out(b_wgt),
    .wgt_out_v(b_v), .wgt_out_rdy(b_rdy), .wgt_out_last(b_last)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model state
  logic [8:0] m_q[$];
  int         m_last_pos[$];
  bit         m_busy = 1'b0;
  bit         m_fin = 1'b0;
  bit         m_stall_prev = 1'b0;
  int         m_issue = 0, m_pops = 0, m_done_cyc = -1;
  int         m_start_cyc = 0, m_first_v = -1, m_last_pop = 0, m_done_obs = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic new_mem();
    int base;
    base = $urandom_range(0, 255);
    for (int i = 0; i < A_TILES; i++) mem_a[i] = 8'(base + i * 37);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_busy = 1'b0;
    m_fin = 1'b0;
    m_stall_prev = 1'b0;
    m_done_cyc = -1;
  endtask

  // One compare per cycle: outputs vs. the expected tile list and run timing.
  task automatic check_a();
    logic pop;
    pop = a_v & a_rdy;
    if (cyc == m_done_cyc) begin
      m_busy = 1'b0;
      m_fin  = 1'b1;
    end
    chk("busy", a_busy, m_busy);
    chk("done", a_done, cyc == m_done_cyc);
    if (a_done) m_done_obs = cyc;
    if (a_en) begin
      chk("issue_while_busy", m_busy, 1);
      chk("issue_addr", a_addr, m_issue % A_TILES);
      chk("issue_occ_ok", (m_issue - m_pops - pop) < 2, 1);
      chk("issue_budget", m_issue < A_TOTAL, 1);
      m_issue++;
    end
    if (!m_busy) chk("v_when_idle", a_v, 0);
    if (m_stall_prev) chk("stall_hold_v", a_v, 1);
    if (a_v) begin
      if (m_q.size() == 0) begin
        chk("tile_unexpected", a_v, 0);
      end else begin
        chk("tile_data", a_wgt, m_q[0][7:0]);
        chk("tile_last", a_last, m_q[0][8]);
        if (m_first_v < 0) m_first_v = cyc;
        if (a_rdy) begin
          if (m_q[0][8]) m_last_pos.push_back(m_pops + 1);
          void'(m_q.pop_front());
          m_pops++;
          m_last_pop = cyc;
          if (m_pops == A_TOTAL) m_done_cyc = cyc + 2;
        end
      end
    end
    m_stall_prev = a_v & ~a_rdy;
    if (a_start && !m_busy && (cyc != m_done_cyc)) begin
      m_busy = 1'b1;
      m_fin  = 1'b0;
      m_q.delete();
      m_last_pos.delete();
      for (int r = 0; r < A_REPS; r++)
        for (int a = 0; a < A_TILES; a++)
          m_q.push_back({(a == A_TILES - 1), mem_a[a]});
      m_issue = 0;
      m_pops = 0;
      m_start_cyc = cyc;
      m_first_v = -1;
    end
  endtask

  task automatic step(input logic st, input logic rdy);
    @(negedge clk);
    a_start = st;
    a_rdy   = rdy;
    #1;
    cyc++;
    if (rst_n) check_a();
  endtask

  // mode 0: rdy=1, 1: pattern 1,0,0,1 with a stray start, 2: random rdy
  task automatic finish_run(input int mode);
    int   k;
    logic r;
    k = 0;
    while (!m_fin && k < 400) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = ((k % 4) == 0) || ((k % 4) == 3);
        default: r = ($urandom_range(0, 99) < 65);
      endcase
      step((mode == 1) && (k == 5), r);
      k++;
    end
    chk("run_completes", m_fin, 1);
    chk("run_tile_count", m_pops, A_TOTAL);
    chk("run_issue_count", m_issue, A_TOTAL);
    chk("run_last_count", m_last_pos.size(), 3);
    if (m_last_pos.size() == 3) begin
      chk("last_pos0", m_last_pos[0], 8);
      chk("last_pos1", m_last_pos[1], 16);
      chk("last_pos2", m_last_pos[2], 24);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, a_busy, 0);
    chk({tag, "_done"}, a_done, 0);
    chk({tag, "_en"},   a_en,   0);
    chk({tag, "_addr"}, a_addr, 0);
    chk({tag, "_v"},    a_v,    0);
    chk({tag, "_last"}, a_last, 0);
    chk({tag, "_wgt"},  a_wgt,  0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] pb, pv, pd, pe;
    int k;
    a_start = 1'b0; a_rdy = 1'b0; b_start = 1'b0; b_rdy = 1'b1; rst_n = 1'b0;
    new_mem();
    mem_b = 8'($urandom_range(0, 255));
    repeat (3) @(negedge clk);
    #1;
    chk_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // full-rate run: pinned latency and duration
    new_mem();
    step(1'b1, 1'b1);
    finish_run(0);
    chk("first_v_latency", m_first_v - m_start_cyc, 3);
    chk("no_gaps_span", m_last_pop - m_first_v, A_TOTAL - 1);
    chk("done_from_start", m_done_obs - m_start_cyc, 28);

    // patterned backpressure with an ignored start mid-run
    new_mem();
    step(1'b1, 1'b1);
    finish_run(1);

    // random backpressure
    for (int n = 0; n < 2; n++) begin
      new_mem();
      step(1'b1, ($urandom_range(0, 1) == 1));
      finish_run(2);
    end

    // hold rdy low: only two reads may go out, head tile is addr 0
    new_mem();
    step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);
    chk("stall_issue_count", m_issue, 2);
    chk("stall_v", a_v, 1);
    chk("stall_head_data", a_wgt, mem_a[0]);
    finish_run(0);

    // reset while draining
    new_mem();
    step(1'b1, 1'b1);
    k = 0;
    while (m_issue < A_TOTAL && k < 100) begin
      step(1'b0, 1'b1);
      k++;
    end
    step(1'b0, 1'b0);
    chk("drain_pending", m_pops < A_TOTAL, 1);
    chk("drain_busy", a_busy, 1);
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("midrst");
    model_reset();
    repeat (3) step(1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step(1'b0, 1'b1);
    new_mem();
    step(1'b1, 1'b1);
    finish_run(2);
    new_mem();
    step(1'b1, 1'b1);
    finish_run(0);
    chk("rerun_done_from_start", m_done_obs - m_start_cyc, 28);

    // single-tile configuration
    pb = '0; pv = '0; pd = '0; pe = '0;
    @(negedge clk);
    b_start = 1'b1;
    #1;
    chk("b_busy_at_start", b_busy, 0);
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      b_start = 1'b0;
      #1;
      pb[j-1] = b_busy;
      pv[j-1] = b_v;
      pd[j-1] = b_done;
      pe[j-1] = b_en;
      if (b_v) begin
        chk("b_tile_data", b_wgt, mem_b);
        chk("b_tile_last", b_last, 1);
      end
      if (b_en) chk("b_addr", b_addr, 0);
    end
    chk("b_busy_pattern", pb, 8'b0000_1111);
    chk("b_v_pattern",    pv, 8'b0000_0100);
    chk("b_done_pattern", pd, 8'b0001_0000);
    chk("b_en_pattern",   pe, 8'b0000_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
